// File: rtl/fft_pkg.sv
// Shared widths, saturation limits and the complex-sample type used by the FFT
// datapath blocks.
package fft_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int TW_W_DEF   = 24;
  localparam int TAG_W_DEF  = 10;

  localparam logic signed [DATA_W_DEF-1:0] SAT_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
  localparam logic signed [DATA_W_DEF-1:0] SAT_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};

  typedef struct packed {
    logic signed [DATA_W_DEF-1:0] re;
    logic signed [DATA_W_DEF-1:0] im;
  } cplx_t;

endpackage

// File: rtl/complex_mult_rnd.sv
// Two-stage complex multiply b*W (or b*conj(W)): full-precision products in S1,
// sum / round-half-up / saturate to DATA_W in S2.
module complex_mult_rnd
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TW_W   = TW_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] b_real,
  input  logic signed [DATA_W-1:0] b_imag,
  input  logic signed [TW_W-1:0]   tw_real,
  input  logic signed [TW_W-1:0]   tw_imag,
  input  logic                     inverse,
  output logic signed [DATA_W-1:0] bw_real,
  output logic signed [DATA_W-1:0] bw_imag,
  output logic                     sat
);

  localparam int MW = (DATA_W > TW_W) ? DATA_W : TW_W;
  localparam int PW = 2 * MW;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] RND = {{(SW-TW_W+1){1'b0}}, 1'b1, {(TW_W-2){1'b0}}};
  localparam logic signed [SW-1:0] HI  = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0] LO  = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;
  logic                     inv_q;
  logic signed [SW-1:0]     sum_re, sum_im, rnd_re, rnd_im;
  logic signed [DATA_W-1:0] nxt_re, nxt_im;
  logic                     sat_re, sat_im;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_rr  <= '0;
      p_ii  <= '0;
      p_ri  <= '0;
      p_ir  <= '0;
      inv_q <= 1'b0;
    end else if (en) begin
      p_rr  <= PW'(b_real) * PW'(tw_real);
      p_ii  <= PW'(b_imag) * PW'(tw_imag);
      p_ri  <= PW'(b_real) * PW'(tw_imag);
      p_ir  <= PW'(b_imag) * PW'(tw_real);
      inv_q <= inverse;
    end
  end

  // Conjugating W is done by flipping the sign of the tw_imag products, so the
  // -2^(TW_W-1) twiddle never needs to be negated on its own.
  always_comb begin
    sum_re = inv_q ? (SW'(p_rr) + SW'(p_ii)) : (SW'(p_rr) - SW'(p_ii));
    sum_im = inv_q ? (SW'(p_ir) - SW'(p_ri)) : (SW'(p_ri) + SW'(p_ir));
    rnd_re = (sum_re + RND) >>> (TW_W - 1);
    rnd_im = (sum_im + RND) >>> (TW_W - 1);
    sat_re = (rnd_re > HI) || (rnd_re < LO);
    sat_im = (rnd_im > HI) || (rnd_im < LO);
    nxt_re = (rnd_re > HI) ? HI[DATA_W-1:0] : (rnd_re < LO) ? LO[DATA_W-1:0] : rnd_re[DATA_W-1:0];
    nxt_im = (rnd_im > HI) ? HI[DATA_W-1:0] : (rnd_im < LO) ? LO[DATA_W-1:0] : rnd_im[DATA_W-1:0];
    sat    = sat_re | sat_im;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bw_real <= '0;
      bw_imag <= '0;
    end else if (en) begin
      bw_real <= nxt_re;
      bw_imag <= nxt_im;
    end
  end

endmodule

// File: rtl/butterfly_pipe.sv
// Radix-2 DIT butterfly A = a + b*W, B = a - b*W as a 3-stage pipeline with
// optional conjugate twiddle, divide-by-2 scaling and a sticky saturation flag.
module butterfly_pipe
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TW_W   = TW_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic signed [DATA_W-1:0] a_real,
  input  logic signed [DATA_W-1:0] a_imag,
  input  logic signed [DATA_W-1:0] b_real,
  input  logic signed [DATA_W-1:0] b_imag,
  input  logic signed [TW_W-1:0]   tw_real,
  input  logic signed [TW_W-1:0]   tw_imag,
  input  logic                     inverse,
  input  logic                     scale,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] A_real,
  output logic signed [DATA_W-1:0] A_imag,
  output logic signed [DATA_W-1:0] B_real,
  output logic signed [DATA_W-1:0] B_imag,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int XW = DATA_W + 2;
  localparam logic signed [XW-1:0] ONE = XW'(1);
  localparam logic signed [XW-1:0] HI  = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [XW-1:0] LO  = {3'b111, {(DATA_W-1){1'b0}}};

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. The whole pipe advances unless the output holds un-taken data
  // (stall = out_valid & !out_ready); in_ready is simply !stall.
  logic stall, adv;
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  logic                     v1, v2, scale1, scale2;
  logic signed [DATA_W-1:0] a1_re, a1_im, a2_re, a2_im;
  logic [TAG_W-1:0]         tag1, tag2;
  logic signed [DATA_W-1:0] bw_re, bw_im;
  logic                     mult_sat;

  complex_mult_rnd #(.DATA_W(DATA_W), .TW_W(TW_W)) u_cmul (
    .clk     (Clk),
    .rst     (Reset),
    .en      (adv),
    .b_real  (b_real),
    .b_imag  (b_imag),
    .tw_real (tw_real),
    .tw_imag (tw_imag),
    .inverse (inverse),
    .bw_real (bw_re),
    .bw_imag (bw_im),
    .sat     (mult_sat)
  );

  // Returns {saturated, value}; scaling rounds half-up before the clamp.
  function automatic logic [DATA_W:0] scale_sat(input logic signed [XW-1:0] x, input logic scl);
    logic signed [XW-1:0] y;
    y = scl ? ((x + ONE) >>> 1) : x;
    if (y > HI)      return {1'b1, HI[DATA_W-1:0]};
    else if (y < LO) return {1'b1, LO[DATA_W-1:0]};
    else             return {1'b0, y[DATA_W-1:0]};
  endfunction

  logic [DATA_W:0] r_ar, r_ai, r_br, r_bi;
  logic            s3_sat, ovf_set;

  always_comb begin
    r_ar    = scale_sat(XW'(a2_re) + XW'(bw_re), scale2);
    r_ai    = scale_sat(XW'(a2_im) + XW'(bw_im), scale2);
    r_br    = scale_sat(XW'(a2_re) - XW'(bw_re), scale2);
    r_bi    = scale_sat(XW'(a2_im) - XW'(bw_im), scale2);
    s3_sat  = r_ar[DATA_W] | r_ai[DATA_W] | r_br[DATA_W] | r_bi[DATA_W];
    ovf_set = adv & ((v1 & mult_sat) | (v2 & s3_sat));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      v1 <= 1'b0; scale1 <= 1'b0; a1_re <= '0; a1_im <= '0; tag1 <= '0;
      v2 <= 1'b0; scale2 <= 1'b0; a2_re <= '0; a2_im <= '0; tag2 <= '0;
      out_valid <= 1'b0;
      A_real <= '0; A_imag <= '0; B_real <= '0; B_imag <= '0;
      out_tag <= '0;
    end else if (adv) begin
      v1 <= in_valid; scale1 <= scale; a1_re <= a_real; a1_im <= a_imag; tag1 <= in_tag;
      v2 <= v1; scale2 <= scale1; a2_re <= a1_re; a2_im <= a1_im; tag2 <= tag1;
      out_valid <= v2;
      A_real <= r_ar[DATA_W-1:0];
      A_imag <= r_ai[DATA_W-1:0];
      B_real <= r_br[DATA_W-1:0];
      B_imag <= r_bi[DATA_W-1:0];
      out_tag <= tag2;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)        ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed bench for butterfly_pipe: latency, conj twiddle, saturation, corner
// product, back-pressure ordering and reset while operations are in flight.
module tb_butterfly_pipe;
  import fft_pkg::*;

  localparam int DW  = 24;
  localparam int TWW = 24;
  localparam int TGW = 10;

  logic           Clk = 1'b0;
  logic           Reset;
  logic [DW-1:0]  a_real, a_imag, b_real, b_imag;
  logic [TWW-1:0] tw_real, tw_imag;
  logic           inverse, scale, in_valid, in_ready;
  logic [TGW-1:0] in_tag, out_tag;
  logic [DW-1:0]  A_real, A_imag, B_real, B_imag;
  logic           out_valid, out_ready, ovf, ovf_clr;

  int checks = 0;
  int errors = 0;
  logic [TGW+DW-1:0] exp_q[$];

  butterfly_pipe #(.DATA_W(DW), .TW_W(TWW), .TAG_W(TGW)) dut (
    .Clk(Clk), .Reset(Reset),
    .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
    .tw_real(tw_real), .tw_imag(tw_imag), .inverse(inverse), .scale(scale),
    .in_tag(in_tag), .in_valid(in_valid), .in_ready(in_ready),
    .A_real(A_real), .A_imag(A_imag), .B_real(B_real), .B_imag(B_imag),
    .out_tag(out_tag), .out_valid(out_valid), .out_ready(out_ready),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  // Clock / watchdog
  initial forever #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_op(input cplx_t a, input cplx_t b, input logic [TWW-1:0] wr,
                          input logic [TWW-1:0] wi, input logic inv, input logic scl,
                          input logic [TGW-1:0] tag);
    a_real = a.re; a_imag = a.im; b_real = b.re; b_imag = b.im;
    tw_real = wr; tw_imag = wi; inverse = inv; scale = scl; in_tag = tag;
    in_valid = 1'b1;
  endtask

  // One accepted op (pipe must be free-flowing); returns 1 time unit after the edge.
  task automatic issue(input cplx_t a, input cplx_t b, input logic [TWW-1:0] wr,
                       input logic [TWW-1:0] wi, input logic inv, input logic scl,
                       input logic [TGW-1:0] tag);
    drive_op(a, b, wr, wi, inv, scl, tag);
    @(posedge Clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge Clk); #1;
      n++;
    end while (!out_valid && n < 10);
    chk(tag, out_valid, 1'b1);
  endtask

  task automatic pulse_clr();
    ovf_clr = 1'b1;
    @(posedge Clk); #1;
    ovf_clr = 1'b0;
  endtask

  initial begin
    logic             acc;
    int               got;
    int               seen;
    logic [TGW+DW-1:0] e;

    Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    a_real = '0; a_imag = '0; b_real = '0; b_imag = '0;
    tw_real = '0; tw_imag = '0; inverse = 1'b0; scale = 1'b0; in_tag = '0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_a_real", A_real, 24'h0);
    chk("rst_b_imag", B_imag, 24'h0);
    chk("rst_out_tag", out_tag, 10'h0);
    Reset = 1'b0;
    @(posedge Clk); #1;
    chk("idle_in_ready", in_ready, 1'b1);

    // Basic op and latency
    issue('{re:24'h100000, im:24'h0}, '{re:24'h100000, im:24'h0}, 24'h400000, 24'h0, 1'b0, 1'b0, 10'h001);
    chk("lat_edge1", out_valid, 1'b0);
    @(posedge Clk); #1;
    chk("lat_edge2", out_valid, 1'b0);
    @(posedge Clk); #1;
    chk("lat_edge3", out_valid, 1'b1);
    chk("basic_A_real", A_real, 24'h180000);
    chk("basic_A_imag", A_imag, 24'h000000);
    chk("basic_B_real", B_real, 24'h080000);
    chk("basic_B_imag", B_imag, 24'h000000);
    chk("basic_tag", out_tag, 10'h001);
    @(posedge Clk); #1;
    chk("bubble_no_valid", out_valid, 1'b0);

    // Inverse flag travels with each op: back-to-back forward then inverse
    issue('{re:24'h0, im:24'h0}, '{re:24'h100000, im:24'h0}, 24'h0, 24'h400000, 1'b0, 1'b0, 10'h002);
    issue('{re:24'h0, im:24'h0}, '{re:24'h100000, im:24'h0}, 24'h0, 24'h400000, 1'b1, 1'b0, 10'h003);
    wait_valid("fwd_valid");
    chk("fwd_A_imag", A_imag, 24'h080000);
    chk("fwd_B_imag", B_imag, 24'hF80000);
    chk("fwd_A_real", A_real, 24'h000000);
    chk("fwd_tag", out_tag, 10'h002);
    wait_valid("inv_valid");
    chk("inv_A_imag", A_imag, 24'hF80000);
    chk("inv_B_imag", B_imag, 24'h080000);
    chk("inv_tag", out_tag, 10'h003);
    chk("inv_ovf_clear", ovf, 1'b0);

    // Saturation, then scaled version of the same op after clearing ovf
    issue('{re:24'h7FFFFF, im:24'h0}, '{re:24'h7FFFFF, im:24'h0}, 24'h7FFFFF, 24'h0, 1'b0, 1'b0, 10'h004);
    wait_valid("sat_valid");
    chk("sat_A_real", A_real, 24'h7FFFFF);
    chk("sat_B_real", B_real, 24'h000001);
    chk("sat_ovf", ovf, 1'b1);
    pulse_clr();
    chk("sat_ovf_clr", ovf, 1'b0);
    issue('{re:24'h7FFFFF, im:24'h0}, '{re:24'h7FFFFF, im:24'h0}, 24'h7FFFFF, 24'h0, 1'b0, 1'b1, 10'h005);
    wait_valid("scl_valid");
    chk("scl_A_real", A_real, 24'h7FFFFF);
    chk("scl_B_real", B_real, 24'h000001);
    chk("scl_ovf_stays", ovf, 1'b0);

    // Most-negative times most-negative product
    issue('{re:24'h0, im:24'h0}, '{re:24'h800000, im:24'h0}, 24'h800000, 24'h0, 1'b0, 1'b0, 10'h006);
    wait_valid("corner_valid");
    chk("corner_A_real", A_real, 24'h7FFFFF);
    chk("corner_B_real", B_real, 24'h800001);
    chk("corner_ovf", ovf, 1'b1);
    pulse_clr();
    chk("corner_ovf_clr", ovf, 1'b0);
    @(posedge Clk); #1;

    // Back-pressure: 8 tagged ops, out_ready low for 4 cycles mid-stream
    got = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          drive_op('{re:DW'(24'h1000 * i + 5), im:24'h0}, '{re:24'h0, im:24'h0}, 24'h0, 24'h0,
                   1'b0, 1'b0, TGW'(10'h010 + i));
          exp_q.push_back({TGW'(10'h010 + i), DW'(24'h1000 * i + 5)});
          for (int t = 0; t < 50; t++) begin
            @(negedge Clk);
            acc = in_ready;
            @(posedge Clk); #1;
            if (acc) break;
          end
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 60 && got < 8; c++) begin
          @(posedge Clk); #1;
          out_ready = !(c >= 4 && c < 8);
          @(negedge Clk);
          if (out_valid && !out_ready && exp_q.size() > 0) begin
            chk("bp_in_ready_low", in_ready, 1'b0);
            chk("bp_hold_tag", out_tag, exp_q[0][TGW+DW-1:DW]);
            chk("bp_hold_A", A_real, exp_q[0][DW-1:0]);
          end
          if (out_valid && out_ready) begin
            chk("bp_queue_nonempty", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              chk("bp_tag", out_tag, e[TGW+DW-1:DW]);
              chk("bp_A_real", A_real, e[DW-1:0]);
              got++;
            end
          end
        end
        out_ready = 1'b1;
      end
    join
    chk("bp_count", got, 8);
    chk("bp_queue_empty", exp_q.size(), 0);
    repeat (2) @(posedge Clk);
    #1;

    // Reset with three ops in flight
    issue('{re:24'h11, im:24'h0}, '{re:24'h0, im:24'h0}, 24'h0, 24'h0, 1'b0, 1'b0, 10'h03A);
    issue('{re:24'h22, im:24'h0}, '{re:24'h0, im:24'h0}, 24'h0, 24'h0, 1'b0, 1'b0, 10'h03B);
    issue('{re:24'h33, im:24'h0}, '{re:24'h0, im:24'h0}, 24'h0, 24'h0, 1'b0, 1'b0, 10'h03C);
    chk("mid_pre_valid", out_valid, 1'b1);
    Reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_A_real", A_real, 24'h0);
    chk("mid_rst_tag", out_tag, 10'h0);
    @(posedge Clk);
    @(posedge Clk); #1;
    Reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge Clk); #1;
      if (out_valid) seen++;
    end
    chk("mid_no_ghosts", seen, 0);
    chk("mid_in_ready", in_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
